// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: stall/flush controller for a 5-stage pipeline.
// Resolves memory wait, taken branch and load-use hazards with fixed priority.
module pipe_hazard_ctrl #(
    parameter int REG_W   = 5,
    parameter int MEM_LAT = 3,
    parameter int CNT_W   = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [REG_W-1:0] id_rs,
    input  logic [REG_W-1:0] id_rt,
    input  logic             id_uses_rs,
    input  logic             id_uses_rt,
    input  logic [REG_W-1:0] ex_rd,
    input  logic             ex_mem_read,
    input  logic             ex_reg_write,
    input  logic             ex_branch_taken,
    input  logic             mem_req,
    output logic             pc_we,
    output logic             if_id_we,
    output logic             id_ex_we,
    output logic             ex_mem_we,
    output logic             mem_wb_we,
    output logic             if_id_flush,
    output logic             id_ex_flush,
    output logic             mem_wb_flush,
    output logic             mem_busy,
    output logic [CNT_W-1:0] stall_cycles
);

    // The wait counter only has to hold MEM_LAT-2; keep it at least one bit wide.
    localparam int                WAIT_W      = (MEM_LAT > 2) ? $clog2(MEM_LAT - 1) : 1;
    localparam int                WAIT_LOAD_I = (MEM_LAT > 2) ? (MEM_LAT - 2) : 0;
    localparam logic [WAIT_W-1:0] WAIT_LOAD   = WAIT_W'(WAIT_LOAD_I);
    localparam logic              MULTI_CYCLE = (MEM_LAT >= 2) ? 1'b1 : 1'b0;

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_WAIT = 1'b1
    } state_e;

    logic              act_q;
    logic              act_d;
    state_e            state_q;
    state_e            state_d;
    logic [WAIT_W-1:0] cnt_q;
    logic [WAIT_W-1:0] cnt_d;
    logic [CNT_W-1:0]  stall_cnt_q;
    logic [CNT_W-1:0]  stall_cnt_d;
    logic              mem_stall_s;
    logic              load_use_s;

    // Memory-wait sequencing: stall decision and next FSM state / wait count.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        mem_stall_s = 1'b0;
        case (state_q)
            ST_RUN: begin
                mem_stall_s = mem_req & MULTI_CYCLE;
                if (act_q && mem_stall_s) begin
                    state_d = ST_WAIT;
                    cnt_d   = WAIT_LOAD;
                end else begin
                    state_d = ST_RUN;
                end
            end
            ST_WAIT: begin
                mem_stall_s = (cnt_q != {WAIT_W{1'b0}});
                if (mem_stall_s) begin
                    cnt_d = cnt_q - WAIT_W'(1);
                end else begin
                    state_d = ST_RUN;
                end
            end
            default: begin
                state_d = ST_RUN;
                cnt_d   = {WAIT_W{1'b0}};
            end
        endcase
    end

    // Load-use hazard between the load in EX and the consumer in ID.
    always_comb begin
        load_use_s = ex_mem_read & ex_reg_write & (ex_rd != {REG_W{1'b0}}) &
                     ((id_uses_rs & (id_rs == ex_rd)) | (id_uses_rt & (id_rt == ex_rd)));
    end

    // Prioritised enable/flush generation; everything is quiet until active.
    always_comb begin
        pc_we        = 1'b0;
        if_id_we     = 1'b0;
        id_ex_we     = 1'b0;
        ex_mem_we    = 1'b0;
        mem_wb_we    = 1'b0;
        if_id_flush  = 1'b0;
        id_ex_flush  = 1'b0;
        mem_wb_flush = 1'b0;
        mem_busy     = 1'b0;
        if (!act_q) begin
            mem_busy = 1'b0;
        end else if (mem_stall_s) begin
            // EX is frozen, so a pending branch is replayed on the release cycle.
            mem_wb_we    = 1'b1;
            mem_wb_flush = 1'b1;
            mem_busy     = 1'b1;
        end else if (ex_branch_taken) begin
            pc_we       = 1'b1;
            if_id_we    = 1'b1;
            id_ex_we    = 1'b1;
            ex_mem_we   = 1'b1;
            mem_wb_we   = 1'b1;
            if_id_flush = 1'b1;
            id_ex_flush = 1'b1;
        end else if (load_use_s) begin
            id_ex_we    = 1'b1;
            id_ex_flush = 1'b1;
            ex_mem_we   = 1'b1;
            mem_wb_we   = 1'b1;
        end else begin
            pc_we     = 1'b1;
            if_id_we  = 1'b1;
            id_ex_we  = 1'b1;
            ex_mem_we = 1'b1;
            mem_wb_we = 1'b1;
        end
    end

    // Activation flag and saturating stall counter next-state.
    always_comb begin
        act_d       = 1'b1;
        stall_cnt_d = stall_cnt_q;
        if (act_q && !pc_we && !(&stall_cnt_q)) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end else begin
            stall_cnt_d = stall_cnt_q;
        end
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            act_q       <= 1'b0;
            state_q     <= ST_RUN;
            cnt_q       <= {WAIT_W{1'b0}};
            stall_cnt_q <= {CNT_W{1'b0}};
        end else begin
            act_q       <= act_d;
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stall_cycles = stall_cnt_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Scoreboard bench for pipe_hazard_ctrl: directed hazard scenarios followed by
// random traffic, checked against a cycle-level behavioural model.
module tb_pipe_hazard_ctrl;

    localparam int REG_W   = 5;
    localparam int MEM_LAT = 3;
    localparam int CNT_W   = 4;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic [REG_W-1:0] id_rs = '0;
    logic [REG_W-1:0] id_rt = '0;
    logic             id_uses_rs = 1'b0;
    logic             id_uses_rt = 1'b0;
    logic [REG_W-1:0] ex_rd = '0;
    logic             ex_mem_read = 1'b0;
    logic             ex_reg_write = 1'b0;
    logic             ex_branch_taken = 1'b0;
    logic             mem_req = 1'b0;
    logic             pc_we, if_id_we, id_ex_we, ex_mem_we, mem_wb_we;
    logic             if_id_flush, id_ex_flush, mem_wb_flush, mem_busy;
    logic [CNT_W-1:0] stall_cycles;

    always #5 clk = ~clk;

    pipe_hazard_ctrl #(.REG_W(REG_W), .MEM_LAT(MEM_LAT), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst),
        .id_rs(id_rs), .id_rt(id_rt), .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
        .ex_rd(ex_rd), .ex_mem_read(ex_mem_read), .ex_reg_write(ex_reg_write),
        .ex_branch_taken(ex_branch_taken), .mem_req(mem_req),
        .pc_we(pc_we), .if_id_we(if_id_we), .id_ex_we(id_ex_we), .ex_mem_we(ex_mem_we),
        .mem_wb_we(mem_wb_we), .if_id_flush(if_id_flush), .id_ex_flush(id_ex_flush),
        .mem_wb_flush(mem_wb_flush), .mem_busy(mem_busy), .stall_cycles(stall_cycles)
    );

    typedef struct packed {
        logic             r;
        logic             mreq;
        logic             br;
        logic             ld;
        logic             wr;
        logic [REG_W-1:0] rd;
        logic [REG_W-1:0] rs;
        logic [REG_W-1:0] rt;
        logic             urs;
        logic             urt;
    } stim_t;

    // ctrl bit order: pc, if_id, id_ex, ex_mem, mem_wb we | if_id, id_ex, mem_wb flush | busy
    typedef struct packed {
        logic [8:0]       ctrl;
        logic [CNT_W-1:0] cnt;
    } exp_t;

    exp_t sb_q[$];
    int   n_vec  = 0;
    int   n_bad  = 0;
    int   n_push = 0;

    // Reference model: activity, cycles elapsed in the current memory access, stall count
    bit m_act   = 1'b0;
    int m_phase = -1;
    int m_cnt   = 0;

    task automatic apply(input stim_t s);
        exp_t       e;
        logic [8:0] c;
        bit         stall;
        bit         lu;
        @(posedge clk);
        #1;
        rst             = s.r;
        mem_req         = s.mreq;
        ex_branch_taken = s.br;
        ex_mem_read     = s.ld;
        ex_reg_write    = s.wr;
        ex_rd           = s.rd;
        id_rs           = s.rs;
        id_rt           = s.rt;
        id_uses_rs      = s.urs;
        id_uses_rt      = s.urt;
        c = 9'b0;
        if (!s.r) begin
            m_act   = 1'b0;
            m_phase = -1;
            m_cnt   = 0;
        end else if (m_act) begin
            if (m_phase < 0 && s.mreq && MEM_LAT >= 2) m_phase = 0;
            stall = (m_phase >= 0) && (m_phase < MEM_LAT - 1);
            lu = s.ld && s.wr && (s.rd != 0) &&
                 ((s.urs && s.rs == s.rd) || (s.urt && s.rt == s.rd));
            if (stall)     c = 9'b00001_001_1;
            else if (s.br) c = 9'b11111_110_0;
            else if (lu)   c = 9'b00111_010_0;
            else           c = 9'b11111_000_0;
        end
        e.ctrl = c;
        e.cnt  = m_cnt[CNT_W-1:0];
        sb_q.push_back(e);
        n_push++;
        if (s.r) begin
            if (m_act) begin
                if (!c[8] && m_cnt < (2**CNT_W) - 1) m_cnt = m_cnt + 1;
                if (m_phase == MEM_LAT - 1) m_phase = -1;
                else if (m_phase >= 0)      m_phase = m_phase + 1;
            end
            m_act = 1'b1;
        end
    endtask

    function automatic stim_t base();
        stim_t s;
        s   = '0;
        s.r = 1'b1;
        return s;
    endfunction

    // Monitor: outputs are combinational and valid every cycle; compare mid-cycle.
    exp_t       mon_e;
    logic [8:0] mon_c;
    always @(negedge clk) begin
        if (sb_q.size() > 0) begin
            mon_e = sb_q.pop_front();
            mon_c = {pc_we, if_id_we, id_ex_we, ex_mem_we, mem_wb_we,
                     if_id_flush, id_ex_flush, mem_wb_flush, mem_busy};
            n_vec++;
            if (mon_c !== mon_e.ctrl || stall_cycles !== mon_e.cnt) begin
                n_bad++;
                $display("FAIL vec%0d t=%0t: ctrl got %b exp %b, stall_cycles got %0d exp %0d",
                         n_vec, $time, mon_c, mon_e.ctrl, stall_cycles, mon_e.cnt);
            end
        end
    end

    initial begin
        stim_t s;
        s = '0;
        repeat (3) apply(s);
        s = base();
        repeat (3) apply(s);
        // load-use, then the same with ex_rd=0
        s = base(); s.ld = 1'b1; s.wr = 1'b1; s.rd = 5'd5; s.rs = 5'd5; s.urs = 1'b1;
        apply(s); apply(base());
        s.rd = 5'd0; s.rs = 5'd0;
        apply(s); apply(base());
        // memory wait with mem_req held
        s = base(); s.mreq = 1'b1;
        repeat (3) apply(s);
        apply(base());
        // branch wins over load-use
        s = base(); s.br = 1'b1; s.ld = 1'b1; s.wr = 1'b1; s.rd = 5'd7; s.rt = 5'd7; s.urt = 1'b1;
        apply(s); apply(base());
        // branch held during memory wait
        s = base(); s.mreq = 1'b1; s.br = 1'b1;
        repeat (3) apply(s);
        apply(base());
        // reset dropped in the WAIT cycle, then a fresh access from RUN
        s = base(); s.mreq = 1'b1;
        apply(s);
        s.r = 1'b0;
        apply(s);
        s = base();
        repeat (2) apply(s);
        s.mreq = 1'b1;
        repeat (3) apply(s);
        apply(base());
        // 20 load-use stalls saturate the 4-bit counter
        s = base(); s.ld = 1'b1; s.wr = 1'b1; s.rd = 5'd3; s.rs = 5'd3; s.urs = 1'b1;
        repeat (20) apply(s);
        apply(base());
        // random traffic on a small register range to hit matches often
        for (int i = 0; i < 500; i++) begin
            s.r    = ($urandom_range(0, 39) != 0);
            s.mreq = ($urandom_range(0, 4) == 0);
            s.br   = ($urandom_range(0, 5) == 0);
            s.ld   = $urandom_range(0, 1);
            s.wr   = ($urandom_range(0, 3) != 0);
            s.rd   = REG_W'($urandom_range(0, 3));
            s.rs   = REG_W'($urandom_range(0, 3));
            s.rt   = REG_W'($urandom_range(0, 3));
            s.urs  = $urandom_range(0, 1);
            s.urt  = $urandom_range(0, 1);
            apply(s);
        end
        repeat (3) @(posedge clk);
        if (sb_q.size() != 0 || n_vec != n_push) begin
            n_bad++;
            $display("FAIL scoreboard drain: checked %0d of %0d pushed, %0d left",
                     n_vec, n_push, sb_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/pipe_hazard_ctrl.md
# pipe_hazard_ctrl

Stall/flush controller for the 5-stage pipeline. It generates the per-stage write enables that freeze the PC, IF/ID, ID/EX, EX/MEM and MEM/WB registers, and the flush (bubble) controls that squash them. It resolves three conditions with fixed priority:
- multi-cycle data-memory access in MEM;
- taken branch resolved in EX;
- load-use hazard between EX and ID.

It sits directly upstream of the pipeline register chain, whose per-register enables it drives. It also keeps a stall-cycle performance counter.

## Interface
- REG_W, 5, register-address width of rs/rt/rd fields
- MEM_LAT, 3, cycles a data-memory access occupies in MEM; values 0 and 1 mean single-cycle (no wait)
- CNT_W, 16, width of the stall performance counter
- clk  in  1  pipeline clock; all state updates on posedge
- rst  in  1  reset, asynchronous, active-low
- id_rs, id_rt  in  REG_W  source registers of the instruction in ID
- id_uses_rs, id_uses_rt  in  1  ID instruction actually reads rs / rt
- ex_rd  in  REG_W  destination register of the instruction in EX
- ex_mem_read  in  1  EX instruction is a load
- ex_reg_write  in  1  EX instruction writes a register
- ex_branch_taken  in  1  branch in EX resolved taken (redirect this cycle)
- mem_req  in  1  instruction in MEM performs a load/store
- pc_we, if_id_we, id_ex_we, ex_mem_we, mem_wb_we  out  1  register write enables
- if_id_flush, id_ex_flush, mem_wb_flush  out  1  load a bubble instead of the upstream value (takes effect only when the same register's we=1)
- mem_busy  out  1  memory wait in progress
- stall_cycles  out  CNT_W  saturating count of cycles with pc_we=0 while active

## Operation
- Registered state: `act` (reset 0), FSM state `{RUN, WAIT}` (reset RUN), wait counter `cnt` (reset 0), `stall_cycles` (reset 0).
- `act` becomes 1 at the first posedge after rst deasserts.
- While act=0, all outputs are 0: no enables, no flushes, mem_busy=0.
- **mem_stall (combinational):**
  - RUN: `mem_req & (MEM_LAT>=2)`.
  - WAIT: `cnt!=0`.
  - mem_req is ignored in WAIT.
- **FSM transitions:**
  - RUN with mem_stall → WAIT, cnt ← MEM_LAT-2.
  - WAIT with cnt!=0 → cnt ← cnt-1.
  - WAIT with cnt==0 → RUN; the MEM instruction advances this cycle.
- **load_use:** `ex_mem_read & ex_reg_write & ex_rd!=0 & ((id_uses_rs & id_rs==ex_rd) | (id_uses_rt & id_rt==ex_rd))`.
- **Priority 1, mem_stall:**
  - pc/if_id/id_ex/ex_mem we=0.
  - mem_wb_we=1, mem_wb_flush=1.
  - mem_busy=1.
  - Branch and load-use are ignored; the EX stage is frozen, so ex_branch_taken stays asserted and is honoured on the release cycle.
- **Priority 2, ex_branch_taken:**
  - All we=1.
  - if_id_flush=1, id_ex_flush=1.
  - A simultaneous load_use is discarded, because the ID instruction is squashed.
- **Priority 3, load_use:**
  - pc_we=0, if_id_we=0.
  - id_ex_we=1, id_ex_flush=1.
  - ex_mem_we=1, mem_wb_we=1.
- **Otherwise:** all we=1, all flushes=0.
- **stall_cycles:** increments on posedge when act=1 and pc_we=0; holds at all-ones (saturates).

## Timing
- Enables and flushes are combinational from the inputs and registered state, valid within the same cycle. Zero latency.
- Memory access with MEM_LAT=N≥2 gives N-1 consecutive stall cycles starting in the request cycle. The instruction leaves MEM in cycle N.
- Load-use stalls exactly 1 cycle. Next cycle the load is in MEM, load_use=0, and the ID instruction proceeds.
- Branch flush costs 2 bubbles; there is no stall.
- rst assertion mid-WAIT:
  - immediately forces act=0, state RUN, cnt=0, stall_cycles=0;
  - outputs drop to 0 asynchronously.
- ex_rd=0 never causes a load-use stall.

## Test plan
- **Reset:** rst=0 for 3 cycles, then release. All outputs are 0 until the first posedge after release, then all we=1, flushes=0, stall_cycles=0.
- **Load-use:**
  - Stimulus: ex_mem_read=1, ex_reg_write=1, ex_rd=5, id_rs=5, id_uses_rs=1 for one cycle.
  - Response: pc_we=0, if_id_we=0, id_ex_flush=1 for 1 cycle; stall_cycles=1.
  - Repeat with ex_rd=0 → no stall.
- **Memory wait:**
  - Stimulus: MEM_LAT=3, mem_req=1 held.
  - Response: 2 cycles of mem_busy=1 with pc..ex_mem we=0 and mem_wb_flush=1; third cycle all we=1. stall_cycles=2.
- **Branch vs load-use:** ex_branch_taken=1 together with a load-use match → all we=1, if_id_flush=id_ex_flush=1, pc_we=1.
- **Branch during memory wait:** mem_req=1, ex_branch_taken=1, MEM_LAT=3.
  - Cycles 0-1: stall, no flush.
  - Cycle 2: if_id_flush=id_ex_flush=1.
- **Async reset mid-WAIT and saturation:**
  - Drop rst in the WAIT cycle → outputs 0 immediately; after release, state is RUN.
  - With CNT_W=4, 20 stall cycles → stall_cycles=15.
